serial_tx_lane: RTL and testbench

//   Byte-to-serial transmit lane feeding one serial input (in1/in2) of the dual-lane dispatcher.

---
 rtl/serial_tx_lane.sv | 246 ++++++++++++++++++++++++
 tb/tb_serial_tx_lane.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_lane.sv
// -----------------------------------------------------------------------------
// serial_tx_lane
//   Byte-to-serial transmit lane feeding one serial input of the dual-lane
//   dispatcher. Bytes are accepted over a valid/ready handshake into a
//   single-entry hold register and shifted out MSB first, one bit per clk.
//   After reset the lane sends SYNC_COUNT alignment (COM) symbols, then sends
//   user bytes or IDLE filler symbols. Downstream almost_full backpressure is
//   honoured only at symbol boundaries.
//
// Configuration macro:
//   SERIAL_TX_PARITY_EN : when defined, every symbol (COM, IDLE, data) is
//                         followed by one even-parity bit (XOR of the 8 bits),
//                         giving a 9-bit frame. Default build: 8-bit frame.
//
// Parameters:
//   COM_SYM     alignment symbol sent during SYNC (default 8'hBC)
//   IDLE_SYM    filler symbol sent when no user data is sent (default 8'h7C)
//   SYNC_COUNT  number of COM symbols sent after reset, >= 1 (default 4)
//
// Ports:
//   clk             in   lane bit clock, rising edge
//   reset           in   synchronous, active-high
//   data_in         in   [7:0] byte to transmit
//   valid_in        in   data_in valid
//   ready_out       out  lane can take a byte this cycle (registered)
//   almost_full_in  in   downstream FIFO almost full
//   serial_out      out  serial bit stream (registered)
//   data_active     out  high for every bit of a symbol carrying user data
// -----------------------------------------------------------------------------
module serial_tx_lane #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDLE_SYM   = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       almost_full_in,
  output logic       serial_out,
  output logic       data_active
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned FRAME = 9;
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned FRAME = 8;
  localparam int unsigned CNT_W = 3;
`endif

  localparam int unsigned SYM_W = $clog2(SYNC_COUNT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] BIT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);
  localparam logic [SYM_W-1:0] SYM_ZERO = SYM_W'(0);
  localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYNC_COUNT - 1);
  localparam logic [SYM_W-1:0] SYM_SAT  = SYM_W'(SYNC_COUNT);

`ifdef SERIAL_TX_PARITY_EN
  // Bit position within the frame that carries the parity bit.
  localparam logic [CNT_W-1:0] BIT_PAR = CNT_W'(8);

  // Even parity over one symbol: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] sym);
    even_parity = ^sym;
  endfunction
`endif

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Registered state
  state_t           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [SYM_W-1:0] sym_cnt_r;
  logic [7:0]       shift_r;
  logic [7:0]       hold_r;
  logic             hold_full_r;
  logic             sym_data_r;   // symbol currently in shift_r carries user data
  logic             serial_r;
  logic             data_active_r;
  logic             ready_r;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_r;        // parity bit of the symbol currently in shift_r
`endif

  // Next-state values
  state_t           state_s;
  logic [CNT_W-1:0] bit_cnt_s;
  logic [SYM_W-1:0] sym_cnt_s;
  logic [7:0]       shift_s;
  logic [7:0]       hold_s;
  logic             hold_full_s;
  logic             sym_data_s;
  logic             ready_s;
  logic             bit_s;        // bit presented on serial_out after this edge
`ifdef SERIAL_TX_PARITY_EN
  logic             par_s;
`endif

  logic             boundary_s;
  logic             xfer_s;

  assign boundary_s = (bit_cnt_r == BIT_LAST);
  // ready_r already encodes ACTIVE && hold empty for this cycle.
  assign xfer_s     = valid_in && ready_r;

  // Next-state logic: symbol sequencing, hold register and handshake.
  always_comb begin
    state_s     = state_r;
    sym_cnt_s   = sym_cnt_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    sym_data_s  = sym_data_r;
    shift_s     = {shift_r[6:0], 1'b0};
    bit_cnt_s   = bit_cnt_r + BIT_ONE;

    // A transfer always lands in the hold register first; the bypass case
    // below empties it again on the same edge.
    if (xfer_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else begin
      hold_s      = hold_r;
      hold_full_s = hold_full_r;
    end

    if (boundary_s) begin
      bit_cnt_s = BIT_ZERO;
      case (state_r)
        ST_SYNC: begin
          sym_data_s = 1'b0;
          if (sym_cnt_r != SYM_SAT) begin
            sym_cnt_s = sym_cnt_r + SYM_ONE;
          end else begin
            sym_cnt_s = sym_cnt_r;
          end
          // The COM symbol ending now is the last one: hold is empty
          // (ready_out was low), so the first ACTIVE symbol is IDLE.
          if (sym_cnt_r == SYM_LAST) begin
            state_s = ST_ACTIVE;
            shift_s = IDLE_SYM;
          end else begin
            state_s = ST_SYNC;
            shift_s = COM_SYM;
          end
        end
        ST_ACTIVE: begin
          if (hold_full_r && !almost_full_in) begin
            shift_s     = hold_r;
            hold_full_s = 1'b0;
            sym_data_s  = 1'b1;
          end else if (hold_full_r) begin
            shift_s    = IDLE_SYM;
            sym_data_s = 1'b0;
          end else if (xfer_s && !almost_full_in) begin
            // Bypass: byte accepted on the boundary goes straight out.
            shift_s     = data_in;
            hold_full_s = 1'b0;
            sym_data_s  = 1'b1;
          end else begin
            shift_s    = IDLE_SYM;
            sym_data_s = 1'b0;
          end
        end
        default: begin
          state_s    = ST_SYNC;
          sym_cnt_s  = SYM_ZERO;
          shift_s    = COM_SYM;
          sym_data_s = 1'b0;
        end
      endcase
    end else begin
      bit_cnt_s = bit_cnt_r + BIT_ONE;
      shift_s   = {shift_r[6:0], 1'b0};
    end

    ready_s = (state_s == ST_ACTIVE) && !hold_full_s;

`ifdef SERIAL_TX_PARITY_EN
    if (bit_cnt_r == BIT_PAR) begin
      bit_s = par_r;
    end else begin
      bit_s = shift_r[7];
    end
    if (boundary_s) begin
      par_s = even_parity(shift_s);
    end else begin
      par_s = par_r;
    end
`else
    bit_s = shift_r[7];
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: counters, shift/hold registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r     <= BIT_ZERO;
      sym_cnt_r     <= SYM_ZERO;
      shift_r       <= COM_SYM;
      hold_r        <= 8'h00;
      hold_full_r   <= 1'b0;
      sym_data_r    <= 1'b0;
      serial_r      <= 1'b0;
      data_active_r <= 1'b0;
      ready_r       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_r         <= even_parity(COM_SYM);
`endif
    end else begin
      bit_cnt_r     <= bit_cnt_s;
      sym_cnt_r     <= sym_cnt_s;
      shift_r       <= shift_s;
      hold_r        <= hold_s;
      hold_full_r   <= hold_full_s;
      sym_data_r    <= sym_data_s;
      serial_r      <= bit_s;
      data_active_r <= sym_data_r;
      ready_r       <= ready_s;
`ifdef SERIAL_TX_PARITY_EN
      par_r         <= par_s;
`endif
    end
  end

  assign serial_out  = serial_r;
  assign data_active = data_active_r;
  assign ready_out   = ready_r;

endmodule

// File: tb/tb_serial_tx_lane.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_lane
//   Scoreboard bench for serial_tx_lane. A symbol-level reference model turns
//   the driven inputs into an expected per-cycle stream (serial bit,
//   data_active, ready_out); a separate monitor pops and compares on negedge.
// -----------------------------------------------------------------------------
module tb_serial_tx_lane;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif
  localparam int         SYNC_COUNT = 4;
  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] IDLE       = 8'h7C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       almost_full_in = 1'b0;
  logic       ready_out;
  logic       serial_out;
  logic       data_active;

  always #5 clk = ~clk;

  serial_tx_lane #(
    .COM_SYM    (COM),
    .IDLE_SYM   (IDLE),
    .SYNC_COUNT (SYNC_COUNT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .almost_full_in (almost_full_in),
    .serial_out     (serial_out),
    .data_active    (data_active)
  );

  typedef struct packed {
    logic ser;
    logic act;
    logic rdy;
  } exp_t;

  exp_t       exp_q[$];       // scoreboard: one entry per clock edge
  logic       pend_bit_q[$];  // bits still to be sent, in wire order
  logic       pend_act_q[$];
  logic [7:0] hold_q[$];      // model of the single-entry hold
  int         m_edge = 0;     // edges since reset release
  bit         m_ready = 1'b0;
  bit         m_took = 1'b0;  // a byte was accepted on the last edge
  int         checks = 0;
  int         errors = 0;

  // Append one symbol (and its parity bit, if enabled) to the wire stream.
  task automatic push_sym(input logic [7:0] s, input logic act);
    for (int i = 7; i >= 0; i--) begin
      pend_bit_q.push_back(s[i]);
      pend_act_q.push_back(act);
    end
`ifdef SERIAL_TX_PARITY_EN
    pend_bit_q.push_back(^s);
    pend_act_q.push_back(act);
`endif
  endtask

  // Reference model: each symbol slot is FRAME edges long; the next symbol
  // is chosen on the last edge of a slot from the lane's priority rules.
  always @(posedge clk) begin : model
    exp_t       e;
    logic       b;
    logic       a;
    bit         xfer;
    bit         used;
    int         nxt;
    logic [7:0] hb;
    if (reset) begin
      pend_bit_q.delete();
      pend_act_q.delete();
      hold_q.delete();
      push_sym(COM, 1'b0);
      m_edge  = 0;
      m_ready = 1'b0;
      m_took  = 1'b0;
      e.ser = 1'b0; e.act = 1'b0; e.rdy = 1'b0;
      exp_q.push_back(e);
    end else begin
      xfer = valid_in && m_ready;
      used = 1'b0;
      b = pend_bit_q.pop_front();
      a = pend_act_q.pop_front();
      if ((m_edge % FRAME) == (FRAME - 1)) begin
        nxt = m_edge / FRAME + 1;
        if (nxt < SYNC_COUNT) begin
          push_sym(COM, 1'b0);
        end else if (hold_q.size() != 0 && !almost_full_in) begin
          hb = hold_q.pop_front();
          push_sym(hb, 1'b1);
        end else if (hold_q.size() != 0) begin
          push_sym(IDLE, 1'b0);
        end else if (xfer && !almost_full_in) begin
          push_sym(data_in, 1'b1);
          used = 1'b1;
        end else begin
          push_sym(IDLE, 1'b0);
        end
      end
      if (xfer && !used) hold_q.push_back(data_in);
      m_took = xfer;
      m_edge++;
      m_ready = (m_edge >= SYNC_COUNT * FRAME) && (hold_q.size() == 0);
      e.ser = b; e.act = a; e.rdy = m_ready;
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("serial_out", serial_out, e.ser);
      chk("data_active", data_active, e.act);
      chk("ready_out", ready_out, e.rdy);
    end
  end

  // Present a byte and hold it until the model sees it accepted.
  task automatic send(input logic [7:0] d);
    int n = 0;
    valid_in = 1'b1;
    data_in  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!m_took && n < 200);
    checks++;
    if (!m_took) begin
      errors++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", d, n);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Sync sequence and idle filler.
    repeat (SYNC_COUNT * FRAME + 2 * FRAME) @(negedge clk);

    // Single byte, then back-to-back bytes.
    send(8'hA5);
    repeat (2 * FRAME) @(negedge clk);
    send(8'h3C);
    send(8'hC3);
    repeat (3 * FRAME) @(negedge clk);

    // Backpressure across two boundaries with a byte held.
    almost_full_in = 1'b1;
    send(8'h5A);
    repeat (2 * FRAME) @(negedge clk);
    almost_full_in = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    // Reset mid-symbol while a byte is held.
    send(8'h99);
    send(8'h42);
    n = 0;
    while ((m_edge % FRAME) != 4 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SYNC_COUNT * FRAME + FRAME) @(negedge clk);

    // Randomized traffic with backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 2400) reset = 1'b1;
      else if (i == 1502 || i == 2403) reset = 1'b0;
      if (!(valid_in && !m_took)) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) almost_full_in = ~almost_full_in;
      @(negedge clk);
    end
    valid_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
